switch_cfg_reg_bank: RTL and testbench

Packet-programmable switch configuration bank. Accepts configuration flits over a valid/ready stream and updates a routing LUT and per-outport dateline bits. Answers read requests with a response flit, and exposes a priority-match route lookup to the switch allocator. It replaces the static register bank in the switch top and sits between the switch's local config port and the route-compute stage.

---
 rtl/switch_pkg.sv | 28 ++
 rtl/switch_lut_lookup.sv | 27 ++
 rtl/switch_cfg_reg_bank.sv | 166 ++++++++++++++++
 tb/tb_switch_cfg_reg_bank.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
// Shared types and field positions for the packet-programmable switch configuration bank.
package switch_pkg;

  localparam int ENTRY_NODE_W = 8;
  localparam int ENTRY_PORT_W = 2;

  localparam int HDR_OP_MSB  = 31;
  localparam int HDR_OP_LSB  = 28;
  localparam int HDR_IDX_MSB = 27;
  localparam int HDR_IDX_LSB = 16;

  localparam logic [15:0] BAD_IDX_PATTERN = 16'hDEAD;

  typedef enum logic [3:0] {
    OP_WR_LUT      = 4'd1,
    OP_WR_DATELINE = 4'd2,
    OP_RD_LUT      = 4'd3,
    OP_RD_DATELINE = 4'd4,
    OP_CLEAR       = 4'd5
  } cfg_op_e;

  typedef struct packed {
    logic                    valid;
    logic [ENTRY_NODE_W-1:0] dest_id;
    logic [ENTRY_PORT_W-1:0] out_port;
  } route_lut_entry_t;

endpackage

// File: rtl/switch_lut_lookup.sv
// Combinational priority match over the routing table; lowest matching index wins.
module switch_lut_lookup
  import switch_pkg::*;
#(
  parameter int TABLE_SIZE = 32,
  parameter int NODE_ID_W  = ENTRY_NODE_W,
  parameter int PORT_W     = ENTRY_PORT_W
) (
  input  route_lut_entry_t       lut_i [TABLE_SIZE],
  input  logic [NODE_ID_W-1:0]   dest_i,
  output logic                   hit_o,
  output logic [PORT_W-1:0]      port_o
);

  // Scan from the top down so the last assignment is the lowest matching index.
  always_comb begin
    hit_o  = 1'b0;
    port_o = '0;
    for (int i = TABLE_SIZE - 1; i >= 0; i--) begin
      if (lut_i[i].valid && (lut_i[i].dest_id == dest_i)) begin
        hit_o  = 1'b1;
        port_o = lut_i[i].out_port;
      end
    end
  end

endmodule

// File: rtl/switch_cfg_reg_bank.sv
// Config bank: decodes header/data flits into routing-table and dateline updates,
// answers reads with a held response flit, and exposes a priority route lookup.
module switch_cfg_reg_bank
  import switch_pkg::*;
#(
  parameter int NUM_OUTPORTS = 4,
  parameter int TABLE_SIZE   = 32,
  parameter int NODE_ID_W    = ENTRY_NODE_W,
  parameter int FLIT_W       = 32
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [FLIT_W-1:0]          in_flit,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [FLIT_W-1:0]          out_flit,
  output logic [NUM_OUTPORTS-1:0]    dateline,
  output route_lut_entry_t           route_lut [TABLE_SIZE],
  input  logic [NODE_ID_W-1:0]       lookup_dest,
  output logic                       lookup_hit,
  output logic [$clog2(NUM_OUTPORTS)-1:0] lookup_port,
  output logic [7:0]                 err_cnt
);

  localparam int PORT_W = $clog2(NUM_OUTPORTS);
  localparam int IDX_W  = $clog2(TABLE_SIZE);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_RESP, S_CLEAR} state_e;

  state_e                  state_q;
  cfg_op_e                 wr_op_q;
  logic [IDX_W-1:0]        idx_q;
  logic                    idx_bad_q;
  route_lut_entry_t        lut_q [TABLE_SIZE];
  logic [NUM_OUTPORTS-1:0] dateline_q;
  logic [FLIT_W-1:0]       out_flit_q;
  logic                    out_valid_q;
  logic [7:0]              err_q;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [FLIT_W-1:0] entry_to_flit(input route_lut_entry_t e);
    logic [FLIT_W-1:0] f;
    f                            = '0;
    f[FLIT_W-1]                  = e.valid;
    f[NODE_ID_W+PORT_W-1:PORT_W] = e.dest_id;
    f[PORT_W-1:0]                = e.out_port;
    return f;
  endfunction

  logic [3:0]       hdr_op;
  logic [11:0]      hdr_idx;
  logic [IDX_W-1:0] hdr_idx_lo;
  logic             hdr_idx_bad;
  route_lut_entry_t data_entry;
  logic             unused_flit;

  assign hdr_op      = in_flit[HDR_OP_MSB:HDR_OP_LSB];
  assign hdr_idx     = in_flit[HDR_IDX_MSB:HDR_IDX_LSB];
  assign hdr_idx_lo  = hdr_idx[IDX_W-1:0];
  assign hdr_idx_bad = (32'(hdr_idx) >= 32'(TABLE_SIZE));

  assign data_entry.valid    = in_flit[FLIT_W-1];
  assign data_entry.dest_id  = in_flit[NODE_ID_W+PORT_W-1:PORT_W];
  assign data_entry.out_port = in_flit[PORT_W-1:0];

  // Header padding bits carry no meaning.
  assign unused_flit = ^in_flit;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= S_IDLE;
      wr_op_q     <= OP_WR_LUT;
      idx_q       <= '0;
      idx_bad_q   <= 1'b0;
      dateline_q  <= '0;
      out_flit_q  <= '0;
      out_valid_q <= 1'b0;
      err_q       <= '0;
      for (int i = 0; i < TABLE_SIZE; i++) lut_q[i] <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            idx_q     <= hdr_idx_lo;
            idx_bad_q <= hdr_idx_bad;
            case (hdr_op)
              OP_WR_LUT: begin
                wr_op_q <= OP_WR_LUT;
                state_q <= S_DATA;
                if (hdr_idx_bad) err_q <= sat_inc(err_q);
              end
              OP_WR_DATELINE: begin
                wr_op_q <= OP_WR_DATELINE;
                state_q <= S_DATA;
              end
              OP_RD_LUT: begin
                // Response is snapshotted here so it cannot change while held.
                if (hdr_idx_bad) begin
                  out_flit_q <= FLIT_W'(BAD_IDX_PATTERN);
                  err_q      <= sat_inc(err_q);
                end else begin
                  out_flit_q <= entry_to_flit(lut_q[hdr_idx_lo]);
                end
                out_valid_q <= 1'b1;
                state_q     <= S_RESP;
              end
              OP_RD_DATELINE: begin
                out_flit_q  <= FLIT_W'(dateline_q);
                out_valid_q <= 1'b1;
                state_q     <= S_RESP;
              end
              OP_CLEAR: state_q <= S_CLEAR;
              default:  err_q   <= sat_inc(err_q);
            endcase
          end
        end
        S_DATA: begin
          if (in_valid) begin
            if (wr_op_q == OP_WR_LUT) begin
              if (!idx_bad_q) lut_q[idx_q] <= data_entry;
            end else begin
              dateline_q <= in_flit[NUM_OUTPORTS-1:0];
            end
            state_q <= S_IDLE;
          end
        end
        S_RESP: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        S_CLEAR: begin
          for (int i = 0; i < TABLE_SIZE; i++) lut_q[i] <= '0;
          dateline_q <= '0;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE) || (state_q == S_DATA);
  assign out_valid = out_valid_q;
  assign out_flit  = out_flit_q;
  assign dateline  = dateline_q;
  assign err_cnt   = err_q;
  assign route_lut = lut_q;

  switch_lut_lookup #(
    .TABLE_SIZE (TABLE_SIZE),
    .NODE_ID_W  (NODE_ID_W),
    .PORT_W     (PORT_W)
  ) u_lookup (
    .lut_i  (lut_q),
    .dest_i (lookup_dest),
    .hit_o  (lookup_hit),
    .port_o (lookup_port)
  );

endmodule

// File: tb/tb_switch_cfg_reg_bank.sv
// Scenario bench for switch_cfg_reg_bank with a response scoreboard and a table model.
module tb_switch_cfg_reg_bank;
  import switch_pkg::*;

  logic             CLK = 1'b0;
  logic             nRST = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_flit = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_flit;
  logic [3:0]       dateline;
  route_lut_entry_t route_lut [32];
  logic [7:0]       lookup_dest = '0;
  logic             lookup_hit;
  logic [1:0]       lookup_port;
  logic [7:0]       err_cnt;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [31:0] exp_q[$];
  logic        m_valid [32];
  logic [7:0]  m_dest  [32];
  logic [1:0]  m_port  [32];
  logic [7:0]  exp_err = '0;

  switch_cfg_reg_bank dut (
    .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .in_ready(in_ready), .in_flit(in_flit),
    .out_valid(out_valid), .out_ready(out_ready), .out_flit(out_flit), .dateline(dateline),
    .route_lut(route_lut), .lookup_dest(lookup_dest), .lookup_hit(lookup_hit),
    .lookup_port(lookup_port), .err_cnt(err_cnt)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [31:0] hdr(input logic [3:0] op, input logic [11:0] idx);
    return {op, idx, 16'h0000};
  endfunction

  function automatic logic [31:0] dat(input logic v, input logic [7:0] dest, input logic [1:0] port);
    return {v, 21'b0, dest, port};
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 32; i++) begin
      m_valid[i] = 1'b0; m_dest[i] = '0; m_port[i] = '0;
    end
  endfunction

  function automatic void bump_err();
    if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
  endfunction

  task automatic send_flit(input logic [31:0] f);
    int n;
    n = 0;
    @(negedge CLK);
    in_valid = 1'b1;
    in_flit  = f;
    while (!in_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL handshake: in_ready stayed %0b for flit %h", in_ready, f);
    end
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wr_lut(input int idx, input logic v, input logic [7:0] dest, input logic [1:0] port);
    send_flit(hdr(4'd1, 12'(idx)));
    send_flit(dat(v, dest, port));
    if (idx < 32) begin
      m_valid[idx] = v; m_dest[idx] = dest; m_port[idx] = port;
    end else begin
      bump_err();
    end
  endtask

  task automatic check_table(input string name);
    int mm;
    mm = 0;
    for (int i = 0; i < 32; i++) begin
      if (route_lut[i].valid !== m_valid[i] || route_lut[i].dest_id !== m_dest[i] ||
          route_lut[i].out_port !== m_port[i]) mm++;
    end
    checks++;
    if (mm != 0) begin
      errors++;
      $display("FAIL %s: %0d table entries differ from expected", name, mm);
    end
  endtask

  task automatic check_err(input string name);
    checks++;
    if (err_cnt !== exp_err) begin
      errors++;
      $display("FAIL %s: err_cnt=%0d expected %0d", name, err_cnt, exp_err);
    end
  endtask

  // Issue a read header, hold out_ready low for `stall` cycles, then drain through the scoreboard.
  task automatic do_read(input logic [31:0] h, input logic [31:0] expv, input int stall);
    logic [31:0] e;
    int n;
    exp_q.push_back(expv);
    send_flit(h);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL read_start: out_valid=%0b in_ready=%0b expected 1/0", out_valid, in_ready);
    end
    for (int k = 0; k < stall; k++) begin
      @(posedge CLK); #1;
      checks++;
      if (out_flit !== expv || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL read_hold: out_flit=%h valid=%0b ready=%0b expected %h/1/0",
                 out_flit, out_valid, in_ready, expv);
      end
    end
    @(negedge CLK);
    out_ready = 1'b1;
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge CLK);
      n++;
    end
    e = exp_q.pop_front();
    checks++;
    if (!out_valid || out_flit !== e) begin
      errors++;
      $display("FAIL read_resp: out_valid=%0b out_flit=%h expected %h", out_valid, out_flit, e);
    end
    @(posedge CLK); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL read_done: out_valid=%0b in_ready=%0b expected 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    model_clear();
    nRST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_flit !== 32'h0 || err_cnt !== 8'h0 ||
        dateline !== 4'h0 || lookup_hit !== 1'b0) begin
      errors++;
      $display("FAIL reset: ready=%0b valid=%0b flit=%h err=%0d dl=%h hit=%0b",
               in_ready, out_valid, out_flit, err_cnt, dateline, lookup_hit);
    end
    check_table("reset_table");
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_wr_lut_lookup();
    @(negedge CLK);
    lookup_dest = 8'h12;
    send_flit(hdr(4'd1, 12'd3));
    @(negedge CLK);
    in_valid = 1'b1;
    in_flit  = dat(1'b1, 8'h12, 2'd2);
    #1;
    checks++;
    if (lookup_hit !== 1'b0) begin
      errors++;
      $display("FAIL lookup_prewrite: lookup_hit=%0b expected 0", lookup_hit);
    end
    @(posedge CLK); #1;
    in_valid = 1'b0;
    m_valid[3] = 1'b1; m_dest[3] = 8'h12; m_port[3] = 2'd2;
    checks++;
    if (lookup_hit !== 1'b1 || lookup_port !== 2'd2) begin
      errors++;
      $display("FAIL lookup_after_write: hit=%0b port=%0d expected 1/2", lookup_hit, lookup_port);
    end
    check_table("wr_lut_table");
    do_read(hdr(4'd3, 12'd3), dat(1'b1, 8'h12, 2'd2), 0);
  endtask

  task automatic test_dateline_read_stall();
    send_flit(hdr(4'd2, 12'd7));
    send_flit(32'h0000_000A);
    checks++;
    if (dateline !== 4'hA) begin
      errors++;
      $display("FAIL dateline_write: dateline=%h expected a", dateline);
    end
    do_read(hdr(4'd4, 12'd0), 32'h0000_000A, 5);
  endtask

  task automatic test_priority();
    wr_lut(1, 1'b1, 8'h05, 2'd1);
    wr_lut(7, 1'b1, 8'h05, 2'd3);
    @(negedge CLK);
    lookup_dest = 8'h05;
    #1;
    checks++;
    if (lookup_hit !== 1'b1 || lookup_port !== 2'd1) begin
      errors++;
      $display("FAIL priority_low: hit=%0b port=%0d expected 1/1", lookup_hit, lookup_port);
    end
    wr_lut(1, 1'b0, 8'h05, 2'd1);
    checks++;
    if (lookup_hit !== 1'b1 || lookup_port !== 2'd3) begin
      errors++;
      $display("FAIL priority_after_inval: hit=%0b port=%0d expected 1/3", lookup_hit, lookup_port);
    end
    check_table("priority_table");
    do_read(hdr(4'd3, 12'd7), dat(1'b1, 8'h05, 2'd3), 2);
  endtask

  task automatic test_bad_index();
    wr_lut(40, 1'b1, 8'h33, 2'd1);
    check_table("bad_idx_table");
    check_err("bad_idx_write");
    bump_err();
    do_read(hdr(4'd3, 12'd40), 32'h0000_DEAD, 1);
    check_err("bad_idx_read");
    send_flit(hdr(4'hF, 12'd0));
    bump_err();
    check_err("bad_opcode");
  endtask

  task automatic test_back_to_back();
    int t0;
    send_flit(hdr(4'd1, 12'd10));
    t0 = cyc;
    send_flit(dat(1'b1, 8'hA0, 2'd0));
    send_flit(hdr(4'd1, 12'd31));
    send_flit(dat(1'b1, 8'hA1, 2'd3));
    m_valid[10] = 1'b1; m_dest[10] = 8'hA0; m_port[10] = 2'd0;
    m_valid[31] = 1'b1; m_dest[31] = 8'hA1; m_port[31] = 2'd3;
    checks++;
    if (cyc - t0 !== 3) begin
      errors++;
      $display("FAIL back_to_back: took %0d cycles expected 3", cyc - t0);
    end
    check_table("back_to_back_table");
  endtask

  task automatic test_clear();
    wr_lut(0, 1'b1, 8'h40, 2'd0);
    wr_lut(2, 1'b1, 8'h41, 2'd1);
    wr_lut(5, 1'b1, 8'h42, 2'd2);
    wr_lut(6, 1'b1, 8'h43, 2'd3);
    @(negedge CLK);
    lookup_dest = 8'h42;
    send_flit(hdr(4'd5, 12'd0));
    checks++;
    if (in_ready !== 1'b0 || lookup_hit !== 1'b1) begin
      errors++;
      $display("FAIL clear_state: in_ready=%0b hit=%0b expected 0/1", in_ready, lookup_hit);
    end
    @(posedge CLK); #1;
    model_clear();
    check_table("clear_table");
    checks++;
    if (dateline !== 4'h0 || lookup_hit !== 1'b0 || lookup_port !== 2'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL clear_outputs: dl=%h hit=%0b port=%0d ready=%0b expected 0/0/0/1",
               dateline, lookup_hit, lookup_port, in_ready);
    end
  endtask

  task automatic test_reset_midwrite();
    wr_lut(9, 1'b1, 8'h77, 2'd1);
    send_flit(hdr(4'd1, 12'd4));
    @(negedge CLK);
    nRST = 1'b0;
    #1;
    model_clear();
    exp_err = '0;
    check_table("midreset_table");
    @(negedge CLK);
    nRST = 1'b1;
    send_flit(32'h8000_0000);
    bump_err();
    check_err("midreset_err");
    check_table("midreset_after_data");
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_state: ready=%0b valid=%0b expected 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_err_saturate();
    for (int i = 0; i < 300; i++) begin
      send_flit(hdr(4'hF, 12'd0));
      bump_err();
    end
    checks++;
    if (err_cnt !== 8'd255 || exp_err !== 8'd255) begin
      errors++;
      $display("FAIL err_saturate: err_cnt=%0d expected 255", err_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_wr_lut_lookup();
    test_dateline_read_stall();
    test_priority();
    test_bad_index();
    test_back_to_back();
    test_clear();
    test_reset_midwrite();
    test_err_saturate();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d responses outstanding expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
